// File: rtl/imp_var_std_unit.sv
// Variance / standard-deviation unit for the LayerNorm datapath.
// Captures E[x] and E[x^2] for one vector (either arrival order), forms the
// clamped variance E[x^2] - E[x]^2, then takes floor(sqrt(var + EPS)) with a
// bit-serial restoring square root that resolves one root bit per cycle.
module imp_var_std_unit #(
    parameter int EX_W   = 8,
    parameter int EX2_W  = 16,
    parameter int EPS    = 1,
    parameter int ROOT_W = EX2_W / 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_Ex_valid,
    input  logic [EX_W-1:0]   i_Ex,
    input  logic              i_Ex2_valid,
    input  logic [EX2_W-1:0]  i_Ex2,
    output logic              o_busy,
    output logic [EX2_W-1:0]  o_var,
    output logic [ROOT_W-1:0] o_std,
    output logic              o_done
);

    localparam int D_W   = EX2_W + 2;
    localparam int REM_W = ROOT_W + 2;
    localparam int CNT_W = $clog2(ROOT_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_VAR  = 2'd1;
    localparam logic [1:0] S_SQRT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Negative differences mean E[x]^2 exceeded E[x^2] through rounding upstream.
    function automatic logic [EX2_W-1:0] clamp_var(input logic signed [D_W-1:0] d);
        return (d < 0) ? '0 : d[EX2_W-1:0];
    endfunction

    // Adding EPS must not wrap a near-full-scale variance back to a tiny radicand.
    function automatic logic [EX2_W-1:0] sat_rad(input logic [EX2_W-1:0] v);
        logic [EX2_W:0] s;
        s = {1'b0, v} + (EX2_W + 1)'(EPS);
        return s[EX2_W] ? '1 : s[EX2_W-1:0];
    endfunction

    logic [1:0]               state_q, state_d;
    logic                     exf_q, exf_d, ex2f_q, ex2f_d;
    logic signed [EX_W-1:0]   ex_q, ex_d;
    logic signed [EX2_W-1:0]  ex2_q, ex2_d;
    logic [EX2_W-1:0]         var_q, var_d;
    logic [EX2_W-1:0]         rad_q, rad_d;
    logic [REM_W-1:0]         rem_q, rem_d;
    logic [ROOT_W-1:0]        root_q, root_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [EX2_W-1:0]         ovar_q, ovar_d;
    logic [ROOT_W-1:0]        ostd_q, ostd_d;
    logic                     done_q, done_d;

    logic signed [2*EX_W-1:0] sq_s;
    logic [EX2_W-1:0]         ex2_pos;
    logic signed [D_W-1:0]    diff;
    logic [EX2_W-1:0]         var_c;
    logic [REM_W-1:0]         rem_sh, trial;
    logic [REM_W-1:0]         rem_nx;
    logic [ROOT_W-1:0]        root_nx;

    // Variance arithmetic and one restoring-root iteration
    always_comb begin
        sq_s    = ex_q * ex_q;
        ex2_pos = ex2_q[EX2_W-1] ? '0 : ex2_q;
        diff    = $signed({2'b00, ex2_pos}) - $signed(D_W'(unsigned'(sq_s)));
        var_c   = clamp_var(diff);
        rem_sh  = {rem_q[REM_W-3:0], rad_q[EX2_W-1 -: 2]};
        trial   = {root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = {root_q[ROOT_W-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh;
            root_nx = {root_q[ROOT_W-2:0], 1'b0};
        end
    end

    // Next-state logic: operand capture, sequencing and output latching
    always_comb begin
        state_d = state_q;
        exf_d   = exf_q;
        ex2f_d  = ex2f_q;
        ex_d    = ex_q;
        ex2_d   = ex2_q;
        var_d   = var_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        ovar_d  = ovar_q;
        ostd_d  = ostd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exf_q && ex2f_q) begin
                    state_d = S_VAR;
                    exf_d   = 1'b0;
                    ex2f_d  = 1'b0;
                end else begin
                    if (i_Ex_valid) begin
                        ex_d  = $signed(i_Ex);
                        exf_d = 1'b1;
                    end
                    if (i_Ex2_valid) begin
                        ex2_d  = $signed(i_Ex2);
                        ex2f_d = 1'b1;
                    end
                end
            end
            S_VAR: begin
                var_d   = var_c;
                rad_d   = sat_rad(var_c);
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                rem_d  = rem_nx;
                root_d = root_nx;
                rad_d  = rad_q << 2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ROOT_W - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ovar_d  = var_q;
                    ostd_d  = root_nx;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            exf_q   <= 1'b0;
            ex2f_q  <= 1'b0;
            ex_q    <= '0;
            ex2_q   <= '0;
            var_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            ovar_q  <= '0;
            ostd_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exf_q   <= exf_d;
            ex2f_q  <= ex2f_d;
            ex_q    <= ex_d;
            ex2_q   <= ex2_d;
            var_q   <= var_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            ovar_q  <= ovar_d;
            ostd_q  <= ostd_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = (state_q != S_IDLE);
    assign o_var  = ovar_q;
    assign o_std  = ostd_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_imp_var_std_unit.sv
// Self-checking bench for imp_var_std_unit: directed cases plus a random batch,
// with expected results queued at stimulus time and compared on each o_done.
module tb_imp_var_std_unit;

    logic               clk;
    logic               rst;
    logic               ex_v;
    logic signed [7:0]  ex;
    logic               ex2_v;
    logic signed [15:0] ex2;
    logic               busy;
    logic [15:0]        ovar;
    logic [7:0]         ostd;
    logic               done;

    int n_tests;
    int n_fail;
    int done_cnt;
    int q_var[$];
    int q_std[$];

    imp_var_std_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_Ex_valid  (ex_v),
        .i_Ex        (ex),
        .i_Ex2_valid (ex2_v),
        .i_Ex2       (ex2),
        .o_busy      (busy),
        .o_var       (ovar),
        .o_std       (ostd),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input int e, input int e2, output int v, output int s);
        int e2p, d, rad;
        e2p = (e2 < 0) ? 0 : e2;
        d   = e2p - e * e;
        v   = (d < 0) ? 0 : d;
        rad = v + 1;
        if (rad > 65535) rad = 65535;
        s = 0;
        while ((s + 1) * (s + 1) <= rad) s++;
    endfunction

    // Scoreboard: every o_done pops one expected result
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (q_var.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("var", int'(ovar), q_var.pop_front());
                check("std", int'(ostd), q_std.pop_front());
            end
        end
    end

    task automatic push_exp(input int v, input int s);
        q_var.push_back(v);
        q_std.push_back(s);
    endtask

    task automatic drive(input logic a_v, input logic signed [7:0] a,
                         input logic b_v, input logic signed [15:0] b);
        @(negedge clk);
        ex_v  = a_v;
        ex    = a;
        ex2_v = b_v;
        ex2   = b;
        @(negedge clk);
        ex_v  = 1'b0;
        ex2_v = 1'b0;
    endtask

    // Counts edges from the sampling edge of the last operand to o_done
    task automatic wait_done(output int lat, output int busy_cyc, output int busy_at_done);
        lat = -1;
        busy_cyc = 0;
        busy_at_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                busy_at_done = int'(busy);
                break;
            end
            if (busy) busy_cyc++;
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, bc, bd, dc, v, s;
        logic signed [7:0]  re;
        logic signed [15:0] re2;
        n_tests = 0;
        n_fail = 0;
        done_cnt = 0;
        rst = 1'b1;
        ex_v = 1'b0;
        ex = '0;
        ex2_v = 1'b0;
        ex2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_var", int'(ovar), 0);
        check("rst_std", int'(ostd), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);

        // Same-cycle operands
        push_exp(16, 4);
        drive(1'b1, 8'sd2, 1'b1, 16'sd20);
        wait_done(lat, bc, bd);
        check("lat_same", lat, 10);
        check("busy_before", bc, 9);
        check("busy_at_done", bd, 1);

        // Ex2 first, Ex three cycles later, negative difference
        @(posedge clk);
        push_exp(0, 1);
        drive(1'b0, 8'sd0, 1'b1, 16'sd5);
        @(negedge clk);
        drive(1'b1, -8'sd3, 1'b0, 16'sd0);
        wait_done(lat, bc, bd);
        check("lat_split", lat, 10);

        // Extremes
        @(posedge clk);
        push_exp(32767, 181);
        drive(1'b1, 8'sd0, 1'b1, 16'sh7FFF);
        wait_done(lat, bc, bd);
        @(posedge clk);
        push_exp(0, 1);
        drive(1'b1, -8'sd128, 1'b1, 16'sd0);
        wait_done(lat, bc, bd);

        // Last Ex wins; a pair strobed during SQRT is dropped
        @(posedge clk);
        push_exp(16, 4);
        drive(1'b1, 8'sd1, 1'b0, 16'sd0);
        drive(1'b1, 8'sd3, 1'b0, 16'sd0);
        drive(1'b0, 8'sd0, 1'b1, 16'sd25);
        dc = done_cnt;
        repeat (3) @(negedge clk);
        drive(1'b1, 8'sd5, 1'b1, 16'sd100);
        wait_done(lat, bc, bd);
        repeat (25) @(negedge clk);
        check("drop_done_cnt", done_cnt - dc, 1);
        check("drop_var_hold", int'(ovar), 16);
        check("drop_std_hold", int'(ostd), 4);
        check("drop_idle", int'(busy), 0);

        // Reset during the 4th SQRT cycle aborts
        dc = done_cnt;
        drive(1'b1, 8'sd0, 1'b1, 16'sd100);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_var", int'(ovar), 0);
        check("abort_std", int'(ostd), 0);
        check("abort_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);
        push_exp(100, 10);
        drive(1'b1, 8'sd0, 1'b1, 16'sd100);
        wait_done(lat, bc, bd);
        check("lat_after_abort", lat, 10);

        // Back-to-back, then random batch; each pair strobed the cycle after o_done
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            re = 8'($urandom_range(0, 255));
            if (i % 2 == 0) re2 = 16'($urandom_range(0, 65535));
            else re2 = 16'(int'(re) * int'(re) + $urandom_range(0, 300) - 150);
            ref_model(int'(re), int'(re2), v, s);
            push_exp(v, s);
            drive(1'b1, re, 1'b1, re2);
            wait_done(lat, bc, bd);
            check("lat_b2b", lat, 10);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", q_var.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
